// File: rtl/fetch_issue_unit.sv
// Fetch/issue stage. It drives the program-memory address and hands the fetched
// opcode to the stall controller. On stall it holds the PC and issues bubbles.
// On jump it redirects, and on HLT it freezes until reset. It also keeps a
// saturating bubble counter and a sticky watchdog for stalls that never clear.
module fetch_issue_unit #(
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0,
    parameter int                     STALL_LIMIT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    pm_addr,
    output logic                   pm_re,
    input  logic [INSTR_WIDTH-1:0] pm_data,
    output logic [5:0]             op_out,
    input  logic                   stall,
    input  logic                   stall_pm,
    input  logic                   jump_en,
    input  logic [PC_WIDTH-1:0]    jump_target,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic                   halted,
    output logic                   stall_err,
    output logic [15:0]            bubble_cnt
);

    localparam int         CNT_W  = $clog2(STALL_LIMIT + 1);
    localparam logic [5:0] OP_HLT = 6'b010001;

    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

    state_t                 state, state_n;
    logic [PC_WIDTH-1:0]    pc, pc_n;
    logic [INSTR_WIDTH-1:0] instr_n;
    logic                   valid_n;
    logic [PC_WIDTH-1:0]    pc_out_n;
    logic                   err_n;
    logic [15:0]            bub_n;
    logic [CNT_W-1:0]       stall_cnt, scnt_n;
    logic                   bump;

    // Memory interface and status outputs. Reads are skipped on continuing
    // stall cycles because memory keeps its last output.
    always_comb begin
        pm_addr = pc;
        op_out  = pm_data[INSTR_WIDTH-1 -: 6];
        pm_re   = jump_en | ~(stall & stall_pm);
        halted  = (state == HALT);
    end

    // Next-state logic. Priority is HALT, then jump, then stall, then advance.
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        instr_n  = instr_out;
        valid_n  = instr_valid;
        pc_out_n = pc_out;
        err_n    = stall_err;
        scnt_n   = stall_cnt;
        bump     = 1'b0;
        case (state)
            HALT: begin
                valid_n = 1'b0;
            end
            default: begin
                if (jump_en) begin
                    pc_n    = jump_target;
                    instr_n = NOP_WORD;
                    valid_n = 1'b0;
                    bump    = 1'b1;
                    scnt_n  = '0;
                    state_n = RUN;
                end else if (stall) begin
                    instr_n = NOP_WORD;
                    valid_n = 1'b0;
                    bump    = 1'b1;
                    if (op_out == OP_HLT) begin
                        state_n = HALT;
                    end else begin
                        state_n = STALL;
                        if (stall_cnt != CNT_W'(STALL_LIMIT))
                            scnt_n = stall_cnt + CNT_W'(1);
                        if (scnt_n == CNT_W'(STALL_LIMIT))
                            err_n = 1'b1;
                    end
                end else begin
                    instr_n  = pm_data;
                    pc_out_n = pc;
                    valid_n  = 1'b1;
                    pc_n     = pc + PC_WIDTH'(1);
                    scnt_n   = '0;
                    state_n  = RUN;
                end
            end
        endcase
        bub_n = (bump && bubble_cnt != 16'hFFFF) ? bubble_cnt + 16'd1 : bubble_cnt;
    end

    // State register. Synchronous reset has the highest priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= '0;
            instr_out   <= NOP_WORD;
            instr_valid <= 1'b0;
            pc_out      <= '0;
            stall_err   <= 1'b0;
            bubble_cnt  <= '0;
            stall_cnt   <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr_out   <= instr_n;
            instr_valid <= valid_n;
            pc_out      <= pc_out_n;
            stall_err   <= err_n;
            bubble_cnt  <= bub_n;
            stall_cnt   <= scnt_n;
        end
    end

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Self-checking bench for fetch_issue_unit. A behavioural model built from the
// stage's rules predicts every output. The bench plays the stall controller:
// it drives stall and feeds stall_pm as stall delayed by one cycle.
module tb_fetch_issue_unit;

    localparam int         LIMIT = 16;
    localparam logic [5:0] HLT   = 6'b010001;

    logic        clk = 1'b0;
    logic        reset, pm_re, stall, stall_pm, jump_en;
    logic        instr_valid, halted, stall_err;
    logic [7:0]  pm_addr, jump_target, pc_out;
    logic [31:0] pm_data, instr_out;
    logic [5:0]  op_out;
    logic [15:0] bubble_cnt;

    logic [31:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [7:0]  m_pc, m_pcout;
    logic [31:0] m_instr;
    logic        m_valid, m_halt, m_err;
    logic [15:0] m_bub;
    int          m_scnt;
    logic        prev_stall;

    fetch_issue_unit #(
        .PC_WIDTH(8), .INSTR_WIDTH(32), .NOP_WORD(32'h0), .STALL_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .pm_addr(pm_addr), .pm_re(pm_re),
        .pm_data(pm_data), .op_out(op_out), .stall(stall), .stall_pm(stall_pm),
        .jump_en(jump_en), .jump_target(jump_target), .instr_out(instr_out),
        .instr_valid(instr_valid), .pc_out(pc_out), .halted(halted),
        .stall_err(stall_err), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;
    always_comb pm_data = mem[pm_addr];

    function automatic logic [66:0] act_vec();
        return {pm_addr, instr_out, instr_valid, pc_out, halted, stall_err, bubble_cnt};
    endfunction
    function automatic logic [66:0] exp_vec();
        return {m_pc, m_instr, m_valid, m_pcout, m_halt, m_err, m_bub};
    endfunction

    task automatic fill_mem(input int hlt_odds);
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if (w[31:26] == HLT) w[31:26] = 6'b000000;
            if (hlt_odds != 0 && $urandom_range(0, hlt_odds - 1) == 0) w[31:26] = HLT;
            mem[i] = w;
        end
    endtask

    // Called at the falling edge. Applies inputs and lets combinational outputs settle.
    task automatic drive(input logic s, input logic j, input logic [7:0] t, input logic r);
        reset = r; stall = s; jump_en = j; jump_target = t;
        stall_pm = prev_stall;
        #1;
    endtask

    // Models one rising edge, then waits for the next falling edge.
    task automatic tick();
        logic [31:0] w;
        @(posedge clk);
        w = mem[m_pc];
        if (reset) begin
            m_pc = 0; m_pcout = 0; m_instr = 0; m_valid = 0;
            m_halt = 0; m_err = 0; m_bub = 0; m_scnt = 0;
        end else if (m_halt) begin
            m_valid = 0;
        end else if (jump_en) begin
            m_pc = jump_target; m_instr = 0; m_valid = 0; m_scnt = 0;
            if (m_bub != 16'hFFFF) m_bub++;
        end else if (stall) begin
            m_instr = 0; m_valid = 0;
            if (m_bub != 16'hFFFF) m_bub++;
            if (w[31:26] == HLT) m_halt = 1;
            else begin
                if (m_scnt < LIMIT) m_scnt++;
                if (m_scnt == LIMIT) m_err = 1;
            end
        end else begin
            m_instr = w; m_pcout = m_pc; m_valid = 1; m_scnt = 0;
            m_pc = m_pc + 8'd1;
        end
        prev_stall = reset ? 1'b0 : stall;
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(0, 0, 8'h00, 1); tick();
        drive(0, 0, 8'h00, 0);
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin drive(0, 0, 8'h00, 0); tick(); end
    endtask

    task automatic test_reset();
        fill_mem(0);
        drive(1, 1, 8'h55, 1); tick();
        n_checks++;
        if (act_vec() !== 67'd0) begin
            n_fail++; $display("FAIL reset_state: got %h expected 0", act_vec());
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 8'h00, 0);
            n_checks++;
            if (pm_re !== 1'b1) begin n_fail++; $display("FAIL seq_pm_re: got %b expected 1", pm_re); end
            tick();
            n_checks++;
            if (pc_out !== 8'(k) || instr_valid !== 1'b1 || instr_out !== mem[k] || bubble_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL seq_issue[%0d]: pc_out=%h valid=%b instr=%h bub=%0d expected pc_out=%h valid=1 instr=%h bub=0",
                         k, pc_out, instr_valid, instr_out, bubble_cnt, 8'(k), mem[k]);
            end
        end
    endtask

    task automatic test_load_stall();
        do_reset(); advance(2);
        drive(1, 0, 8'h00, 0);
        n_checks++;
        if (pm_re !== 1'b1) begin n_fail++; $display("FAIL ld_pm_re1: got %b expected 1", pm_re); end
        tick();
        n_checks++;
        if (pm_addr !== 8'd2 || instr_valid !== 1'b0 || instr_out !== 32'd0 || bubble_cnt !== 16'd1) begin
            n_fail++; $display("FAIL ld_bubble: addr=%h valid=%b instr=%h bub=%0d expected 02/0/0/1",
                               pm_addr, instr_valid, instr_out, bubble_cnt);
        end
        drive(0, 0, 8'h00, 0);
        n_checks++;
        if (pm_re !== 1'b1) begin n_fail++; $display("FAIL ld_pm_re2: got %b expected 1", pm_re); end
        tick();
        n_checks++;
        if (pc_out !== 8'd2 || instr_out !== mem[2] || instr_valid !== 1'b1 || pm_addr !== 8'd3) begin
            n_fail++; $display("FAIL ld_issue: pc_out=%h instr=%h valid=%b addr=%h expected 02/%h/1/03",
                               pc_out, instr_out, instr_valid, pm_addr, mem[2]);
        end
        advance(1);
        n_checks++;
        if (pc_out !== 8'd3 || bubble_cnt !== 16'd1) begin
            n_fail++; $display("FAIL ld_once: pc_out=%h bub=%0d expected 03/1", pc_out, bubble_cnt);
        end
    endtask

    task automatic test_jump();
        do_reset(); advance(5);
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 8'h00, 0);
            n_checks++;
            if (pm_re !== (c == 0)) begin n_fail++; $display("FAIL jmp_pm_re[%0d]: got %b expected %b", c, pm_re, c == 0); end
            tick();
            n_checks++;
            if (pm_addr !== 8'd5 || instr_valid !== 1'b0) begin
                n_fail++; $display("FAIL jmp_hold[%0d]: addr=%h valid=%b expected 05/0", c, pm_addr, instr_valid);
            end
        end
        drive(1, 1, 8'h20, 0);
        n_checks++;
        if (pm_re !== 1'b1) begin n_fail++; $display("FAIL jmp_pm_re_jump: got %b expected 1", pm_re); end
        tick();
        n_checks++;
        if (pm_addr !== 8'h20 || instr_valid !== 1'b0 || bubble_cnt !== 16'd4) begin
            n_fail++; $display("FAIL jmp_redirect: addr=%h valid=%b bub=%0d expected 20/0/4", pm_addr, instr_valid, bubble_cnt);
        end
        advance(1);
        n_checks++;
        if (pc_out !== 8'h20 || instr_out !== mem[8'h20] || instr_valid !== 1'b1) begin
            n_fail++; $display("FAIL jmp_target_issue: pc_out=%h instr=%h expected 20/%h", pc_out, instr_out, mem[8'h20]);
        end
    endtask

    task automatic test_halt();
        logic [31:0] w;
        fill_mem(0);
        w = $urandom; w[31:26] = HLT; mem[7] = w;
        do_reset(); advance(7);
        drive(1, 0, 8'h00, 0);
        n_checks++;
        if (op_out !== HLT) begin n_fail++; $display("FAIL hlt_op_out: got %b expected %b", op_out, HLT); end
        tick();
        n_checks++;
        if (halted !== 1'b1 || pm_addr !== 8'd7) begin
            n_fail++; $display("FAIL hlt_enter: halted=%b addr=%h expected 1/07", halted, pm_addr);
        end
        drive(0, 1, 8'h40, 0); tick();
        drive(0, 0, 8'h00, 0); tick();
        n_checks++;
        if (act_vec() !== exp_vec() || halted !== 1'b1 || pm_addr !== 8'd7 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL hlt_frozen: got %h expected %h", act_vec(), exp_vec());
        end
        do_reset();
        n_checks++;
        if (halted !== 1'b0 || pm_addr !== 8'd0) begin
            n_fail++; $display("FAIL hlt_reset: halted=%b addr=%h expected 0/00", halted, pm_addr);
        end
        fill_mem(0);
    endtask

    task automatic test_watchdog();
        do_reset(); advance(3);
        for (int c = 1; c <= LIMIT; c++) begin
            drive(1, 0, 8'h00, 0); tick();
            n_checks++;
            if (stall_err !== (c >= LIMIT)) begin
                n_fail++; $display("FAIL wd_err[%0d]: got %b expected %b", c, stall_err, c >= LIMIT);
            end
        end
        advance(2);
        n_checks++;
        if (stall_err !== 1'b1 || pc_out !== 8'd4 || instr_valid !== 1'b1 || pm_addr !== 8'd5) begin
            n_fail++; $display("FAIL wd_sticky: err=%b pc_out=%h valid=%b addr=%h expected 1/04/1/05",
                               stall_err, pc_out, instr_valid, pm_addr);
        end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        drive(0, 1, 8'hFF, 0); tick();
        advance(1);
        n_checks++;
        if (pc_out !== 8'hFF || pm_addr !== 8'h00) begin
            n_fail++; $display("FAIL wrap: pc_out=%h addr=%h expected ff/00", pc_out, pm_addr);
        end
        drive(1, 0, 8'h00, 0); tick();
        drive(1, 0, 8'h00, 0); tick();
        drive(1, 0, 8'h00, 1); tick();
        n_checks++;
        if (act_vec() !== 67'd0) begin
            n_fail++; $display("FAIL reset_mid_stall: got %h expected 0", act_vec());
        end
    endtask

    task automatic test_random();
        logic        s, j, r;
        logic [7:0]  t;
        logic [31:0] w;
        fill_mem(24);
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0) || (m_halt && $urandom_range(0, 7) == 0);
            j = ($urandom_range(0, 11) == 0);
            s = ($urandom_range(0, 2) == 0);
            t = 8'($urandom);
            drive(s, j, t, r);
            w = mem[m_pc];
            n_checks++;
            if (pm_re !== (j | ~(s & stall_pm)) || op_out !== w[31:26]) begin
                n_fail++; $display("FAIL rand_comb[%0d]: pm_re=%b op=%b expected %b/%b",
                                   i, pm_re, op_out, j | ~(s & stall_pm), w[31:26]);
            end
            tick();
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rand_state[%0d]: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; stall_pm = 1'b0; jump_en = 1'b0; jump_target = '0;
        prev_stall = 1'b0;
        m_pc = 0; m_pcout = 0; m_instr = 0; m_valid = 0; m_halt = 0; m_err = 0; m_bub = 0; m_scnt = 0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_load_stall();
        test_jump();
        test_halt();
        test_watchdog();
        test_wrap_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_issue_unit.md
Name: fetch_issue_unit

Overview:
- Instruction fetch/issue stage of the MIPS pipeline; it responds to the stall controller's requests.
- Drives the program-memory address and presents the fetched opcode to the stall controller.
- Consumes the returned stall/stall_pm and holds the PC, injecting bubbles, redirecting on jumps or freezing on halt.
- Also keeps a saturating bubble counter and a stuck-stall watchdog for debug.

Parameters:
PC_WIDTH, 8, program counter / program-memory address width
INSTR_WIDTH, 32, instruction width; opcode is bits [INSTR_WIDTH-1:INSTR_WIDTH-6]
NOP_WORD, 0, instruction word issued as a bubble
STALL_LIMIT, 16, consecutive non-halt stall cycles before stall_err sets (>=2)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
pm_addr  out  PC_WIDTH  program-memory address (= pc register)
pm_re  out  1  program-memory read enable
pm_data  in  INSTR_WIDTH  instruction word at pm_addr, valid same cycle
op_out  out  6  opcode field of pm_data to the stall controller, combinational
stall  in  1  combinational stall request from the stall controller
stall_pm  in  1  stall delayed one cycle by the stall controller
jump_en  in  1  redirect request from execute stage
jump_target  in  PC_WIDTH  redirect address
instr_out  out  INSTR_WIDTH  issued instruction register
instr_valid  out  1  instr_out holds a real instruction
pc_out  out  PC_WIDTH  address of instr_out
halted  out  1  HLT reached; core frozen
stall_err  out  1  sticky watchdog flag
bubble_cnt  out  16  saturating count of injected bubbles

Behaviour:
- Reset (synchronous, active-high, highest priority): pc=0, instr_out=NOP_WORD, instr_valid=0, pc_out=0, halted=0, stall_err=0, bubble_cnt=0, stall_cnt=0, state=RUN.
- HLT opcode = 6'b010001.
- pm_re = jump_en | ~(stall & stall_pm). Reads are suppressed on continuing stall cycles; memory holds its output.
- States:
  - RUN: no stall in progress.
  - STALL: stall persisted from the previous cycle.
  - HALT: terminal until reset.
- Per-cycle priority (not reset): HALT > jump_en > stall > advance.
- HALT: pc, instr_out and pc_out hold. instr_valid=0. jump_en, stall and pm_data are ignored. Only reset exits.
- jump_en=1 (state RUN or STALL):
  - pc<=jump_target; instr_out<=NOP_WORD; instr_valid<=0.
  - bubble_cnt increments; stall_cnt clears; next state=RUN.
  - Jump overrides a concurrent stall, including HLT on pm_data.
- stall=1, no jump:
  - pc holds; instr_out<=NOP_WORD; instr_valid<=0; bubble_cnt increments.
  - If op_out==HLT: next state=HALT, halted<=1 (registered, visible the cycle after).
  - Otherwise: next state=STALL; stall_cnt increments, saturating at STALL_LIMIT.
  - When stall_cnt reaches STALL_LIMIT, stall_err<=1 (sticky until reset).
- stall=0, no jump:
  - instr_out<=pm_data; pc_out<=pc; instr_valid<=1; pc<=pc+1 (wraps 2^PC_WIDTH-1 -> 0).
  - stall_cnt clears; next state=RUN.
- stall_pm=1 while in RUN: tolerated, affects only pm_re.
- bubble_cnt saturates at 16'hFFFF.
- Issue latency: pm_data sampled at edge N appears on instr_out after edge N. A stalled instruction issues on the first cycle stall=0, so it issues exactly once.
- Reset asserted mid-stall or in HALT: all state returns to reset values on that edge.

Test Plan:
1. Reset, memory words 0..3 non-stalling, stall=0 -> pc_out 0,1,2,3 on successive cycles, instr_valid=1, bubble_cnt=0.
2. LD at address 2: stall=1 for one cycle -> pc holds at 2 for 2 cycles, one NOP with instr_valid=0, LD issued once with pc_out=2, bubble_cnt=1, pm_re stays 1.
3. stall held 3 cycles (jump-type op at 5), then jump_en=1, jump_target=8x20 -> 3 bubbles, pm_re=0 on cycles 2-3, next pm_addr=8'h20, instr_valid=0 that cycle, bubble_cnt=4.
4. HLT (010001) at address 7 -> halted=1 the cycle after stall; pc stays 7; concurrent jump_en ignored afterwards; reset -> pc=0, halted=0.
5. stall forced high for 16 cycles with non-HLT opcode -> stall_err=1 after 16th stalled edge and stays 1 after stall drops; pc advances normally afterwards.
6. PC at 8'hFF with stall=0 -> next pm_addr=8'h00. Assert reset during an active stall -> all outputs at reset values next cycle.
